// File: rtl/multi_pulse_pkg.sv
// Shared types and constants for the multi-channel LED pulse core.
//   mode_t   : per-channel operating mode (off, steady, blink, counted burst)
//   state_t  : channel FSM state
//   A_*      : word addresses within the MMIO slot
package multi_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STEADY = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_BURST  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam logic [4:0] A_ENABLE   = 5'd0;
  localparam logic [4:0] A_STATUS   = 5'd1;
  localparam logic [4:0] A_PRESCALE = 5'd2;
  localparam logic [4:0] A_CH_BASE  = 5'd16;

  // A programmed prescale of 0 runs the tick at full rate, same as 1.
  function automatic logic [23:0] prescale_eff(input logic [23:0] p);
    return (p == 24'd0) ? 24'd1 : p;
  endfunction

endpackage

// File: rtl/multi_pulse_core_if.sv
// Slot bus for the pulse core.
//   cs, read, write : slot select and strobes
//   addr            : word address within the slot
//   wr_data         : write data
//   rd_data         : read data returned by the slave
interface multi_pulse_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/pulse_channel.sv
// One LED channel: FSM, phase counter and remaining-burst counter.
//   tick       : shared prescaler tick (phase counters advance on it)
//   restart    : reload and re-enter the start state this cycle
//   enable     : 0 holds the channel idle with the LED low
//   on_time, off_time, mode, count : channel configuration (already
//                updated with any same-cycle register write)
//   led        : registered LED output
//   done_pulse : one-cycle pulse when a burst completes
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | not cycling; LED high only for steady mode
// ST_ON   | on phase of a blink/burst unit, LED high
// ST_OFF  | off phase of a blink/burst unit, LED low
module pulse_channel
  import multi_pulse_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        restart,
  input  logic        enable,
  input  logic [15:0] on_time,
  input  logic [15:0] off_time,
  input  mode_t       mode,
  input  logic [7:0]  count,
  output logic        led,
  output logic        done_pulse
);

  state_t      state;
  logic [15:0] phase_cnt;
  logic [7:0]  remain;

  logic burst, cyclic, on_zero, off_zero, on_end, off_end, last_unit;

  assign burst     = (mode == MODE_BURST);
  assign cyclic    = (mode == MODE_BLINK) || burst;
  assign on_zero   = (on_time == 16'd0);
  assign off_zero  = (off_time == 16'd0);
  assign on_end    = tick && (phase_cnt == on_time - 16'd1);
  assign off_end   = tick && (phase_cnt == off_time - 16'd1);
  assign last_unit = (remain <= 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase_cnt  <= '0;
      remain     <= '0;
      led        <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (!enable) begin
        state     <= ST_IDLE;
        phase_cnt <= '0;
        led       <= 1'b0;
      end else if (restart) begin
        phase_cnt <= '0;
        remain    <= count;
        if (!cyclic) begin
          state <= ST_IDLE;
          led   <= (mode == MODE_STEADY);
        end else if ((on_zero && off_zero) || (burst && count == 8'd0)) begin
          // Nothing to blink: a burst of this shape is complete at once.
          state      <= ST_IDLE;
          led        <= 1'b0;
          done_pulse <= burst;
        end else if (!on_zero) begin
          state <= ST_ON;
          led   <= 1'b1;
        end else begin
          // Zero-length on phase is skipped; units are all off time.
          state <= ST_OFF;
          led   <= 1'b0;
        end
      end else begin
        case (state)
          ST_ON: begin
            if (on_end) begin
              phase_cnt <= '0;
              if (!off_zero) begin
                state <= ST_OFF;
                led   <= 1'b0;
              end else if (burst) begin
                // No off phase: a unit ends with its on phase.
                if (last_unit) begin
                  state      <= ST_IDLE;
                  led        <= 1'b0;
                  done_pulse <= 1'b1;
                end else begin
                  remain <= remain - 8'd1;
                end
              end
            end else if (tick) begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end
          ST_OFF: begin
            if (off_end) begin
              phase_cnt <= '0;
              if (burst && last_unit) begin
                state      <= ST_IDLE;
                led        <= 1'b0;
                done_pulse <= 1'b1;
              end else begin
                if (burst) remain <= remain - 8'd1;
                if (!on_zero) begin
                  state <= ST_ON;
                  led   <= 1'b1;
                end
              end
            end else if (tick) begin
              phase_cnt <= phase_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_pulse_core.sv
// N-channel LED pulse/blink core for an MMIO slot.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slot bus (slave side); rd_data is a combinational decode
//   led_vec    : registered LED outputs, one per channel
// Holds the register file, shared tick prescaler, read mux, sticky done
// flags and one pulse_channel per channel.
module multi_pulse_core
  import multi_pulse_pkg::*;
#(
  parameter int N_CH         = 8,
  parameter int DEF_PRESCALE = 100_000
) (
  input  logic             clk,
  input  logic             reset,
  multi_pulse_core_if.slave bus,
  output logic [N_CH-1:0]  led_vec
);

  logic             wr_en, ch_hit;
  logic [2:0]       ch_idx;
  logic [N_CH-1:0]  enable_q, enable_nxt, done_q, done_pulse, restart, w1c;
  logic [23:0]      presc_q, presc_nxt, tick_cnt;
  logic             presc_wr, tick;
  logic [31:0]      time_q [N_CH];
  logic [31:0]      time_nxt [N_CH];
  mode_t            mode_q [N_CH];
  mode_t            mode_nxt [N_CH];
  logic [7:0]       count_q [N_CH];
  logic [7:0]       count_nxt [N_CH];
  logic [31:0]      rd_mux;
  logic             unused_read;

  assign wr_en       = bus.cs && bus.write;
  assign ch_idx      = bus.addr[3:1];
  assign ch_hit      = (bus.addr >= A_CH_BASE) && (int'(ch_idx) < N_CH);
  assign unused_read = bus.read;

  // Next register values. Channels are fed these rather than the registered
  // copies so a restart acts on the configuration written in the same cycle.
  always_comb begin
    enable_nxt = enable_q;
    presc_nxt  = presc_q;
    presc_wr   = 1'b0;
    w1c        = '0;
    time_nxt   = time_q;
    mode_nxt   = mode_q;
    count_nxt  = count_q;
    restart    = '0;
    if (wr_en) begin
      if (bus.addr == A_ENABLE) enable_nxt = bus.wr_data[N_CH-1:0];
      if (bus.addr == A_STATUS) w1c = bus.wr_data[8 +: N_CH];
      if (bus.addr == A_PRESCALE) begin
        presc_nxt = bus.wr_data[23:0];
        presc_wr  = 1'b1;
      end
      for (int i = 0; i < N_CH; i++) begin
        if (ch_hit && int'(ch_idx) == i) begin
          restart[i] = 1'b1;
          if (bus.addr[0]) begin
            mode_nxt[i]  = mode_t'(bus.wr_data[1:0]);
            count_nxt[i] = bus.wr_data[15:8];
          end else begin
            time_nxt[i] = bus.wr_data;
          end
        end
      end
    end
    restart = restart | (enable_nxt & ~enable_q);
  end

  assign tick = (tick_cnt == prescale_eff(presc_q) - 24'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      presc_q  <= 24'(DEF_PRESCALE);
      done_q   <= '0;
      tick_cnt <= '0;
      for (int i = 0; i < N_CH; i++) begin
        time_q[i]  <= '0;
        mode_q[i]  <= MODE_OFF;
        count_q[i] <= '0;
      end
    end else begin
      enable_q <= enable_nxt;
      presc_q  <= presc_nxt;
      time_q   <= time_nxt;
      mode_q   <= mode_nxt;
      count_q  <= count_nxt;
      // Set beats a same-cycle write-1-to-clear.
      done_q   <= (done_q & ~w1c) | done_pulse;
      tick_cnt <= (presc_wr || tick) ? 24'd0 : tick_cnt + 24'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    if (bus.addr == A_ENABLE) begin
      rd_mux[N_CH-1:0] = enable_q;
    end else if (bus.addr == A_STATUS) begin
      rd_mux[N_CH-1:0]  = led_vec;
      rd_mux[8 +: N_CH] = done_q;
    end else if (bus.addr == A_PRESCALE) begin
      rd_mux[23:0] = presc_q;
    end else if (ch_hit) begin
      if (bus.addr[0]) rd_mux = {16'd0, count_q[ch_idx], 6'd0, mode_q[ch_idx]};
      else             rd_mux = time_q[ch_idx];
    end
  end

  assign bus.rd_data = rd_mux;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pulse_channel u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .restart    (restart[g]),
      .enable     (enable_nxt[g]),
      .on_time    (time_nxt[g][15:0]),
      .off_time   (time_nxt[g][31:16]),
      .mode       (mode_nxt[g]),
      .count      (count_nxt[g]),
      .led        (led_vec[g]),
      .done_pulse (done_pulse[g])
    );
  end

endmodule

// File: tb/tb_multi_pulse_core.sv
module tb_multi_pulse_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] led_vec;

  multi_pulse_core_if bus();

  multi_pulse_core #(.N_CH(8), .DEF_PRESCALE(100_000)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .led_vec (led_vec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: registers plus "ticks since restart" per channel.
  int         m_on [8], m_off [8], m_mode [8], m_cnt [8], m_j [8];
  logic [31:0] m_time [8];
  logic [7:0] m_en, m_done, m_pend;
  int         m_presc, m_peff, since_pw;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_on[i] = 0; m_off[i] = 0; m_mode[i] = 0; m_cnt[i] = 0; m_j[i] = 0; m_time[i] = 0;
    end
    m_en = 0; m_done = 0; m_pend = 0;
    m_presc = 100000; m_peff = 100000; since_pw = 0;
  endtask

  // LED after j ticks: high during the first on_time ticks of each period.
  function automatic logic exp_led(input int i);
    int p;
    p = m_on[i] + m_off[i];
    if (!m_en[i]) return 1'b0;
    case (m_mode[i])
      1: return 1'b1;
      2: return (p != 0) && ((m_j[i] % p) < m_on[i]);
      3: return (p != 0) && (m_j[i] < m_cnt[i] * p) && ((m_j[i] % p) < m_on[i]);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [7:0] lv;
    int ch;
    for (int i = 0; i < 8; i++) lv[i] = exp_led(i);
    ch = (int'(a) - 16) / 2;
    if (a == 5'd0) return {24'd0, m_en};
    if (a == 5'd1) return {16'd0, m_done, lv};
    if (a == 5'd2) return 32'(m_presc);
    if (a >= 5'd16) begin
      if (a[0]) return {16'd0, 8'(m_cnt[ch]), 6'd0, 2'(m_mode[ch])};
      return m_time[ch];
    end
    return 32'd0;
  endfunction

  // One clock: update the model from what the bench is driving, then
  // compare every LED at the following falling edge.
  task automatic cycle();
    logic [7:0] rs, w1c;
    logic       tk;
    int         k, ch, p;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      k = since_pw + 1;
      tk = (k % m_peff) == 0;
      since_pw = k;
      rs = 0; w1c = 0;
      if (bus.cs && bus.write) begin
        if (bus.addr == 5'd0) begin
          rs = bus.wr_data[7:0] & ~m_en;
          m_en = bus.wr_data[7:0];
        end else if (bus.addr == 5'd1) begin
          w1c = bus.wr_data[15:8];
        end else if (bus.addr == 5'd2) begin
          m_presc = int'(bus.wr_data[23:0]);
          m_peff = (m_presc == 0) ? 1 : m_presc;
          since_pw = 0;
        end else if (bus.addr >= 5'd16) begin
          ch = (int'(bus.addr) - 16) / 2;
          rs[ch] = 1'b1;
          if (bus.addr[0]) begin
            m_mode[ch] = int'(bus.wr_data[1:0]);
            m_cnt[ch] = int'(bus.wr_data[15:8]);
          end else begin
            m_time[ch] = bus.wr_data;
            m_on[ch] = int'(bus.wr_data[15:0]);
            m_off[ch] = int'(bus.wr_data[31:16]);
          end
        end
      end
      m_done = (m_done & ~w1c) | m_pend;
      for (int i = 0; i < 8; i++) begin
        if (rs[i]) m_j[i] = 0;
        else if (tk) m_j[i]++;
        p = m_on[i] + m_off[i];
        // A burst completes on the event that brings j to count*period.
        m_pend[i] = m_en[i] && m_mode[i] == 3 && (rs[i] || tk) && m_j[i] == m_cnt[i] * p;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("led[%0d]", i), 32'(led_vec[i]), 32'(exp_led(i)));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    cycle();
    bus.cs = 1'b0; bus.write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
    #1;
    v = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  task automatic rd_model(input logic [4:0] a);
    logic [31:0] v;
    rd(a, v);
    chk($sformatf("read[%0d]", a), v, exp_read(a));
  endtask

  logic [31:0] v;
  logic [9:0]  pat;
  int          pulses;
  logic        prev;

  initial begin
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
    model_reset();
    run(3);
    reset = 1'b0;
    run(2);

    // Reset values and read-back.
    rd(5'd2, v); chk("reset_prescale", v, 32'd100000);
    rd(5'd0, v); chk("reset_enable", v, 32'd0);
    rd(5'd1, v); chk("reset_status", v, 32'd0);
    wr(5'd16, 32'h0002_0003);
    rd(5'd16, v); chk("time0_rb", v, 32'h0002_0003);
    rd(5'd5, v); chk("unmapped_rd", v, 32'd0);

    // Blink timing at full tick rate.
    wr(5'd2, 32'd1);
    wr(5'd0, 32'd1);
    wr(5'd16, 32'h0002_0003);
    wr(5'd17, 32'd2);
    pat[9] = led_vec[0];
    for (int k = 8; k >= 0; k--) begin cycle(); pat[k] = led_vec[0]; end
    chk("blink_pattern", 32'(pat), 32'(10'b1110011100));

    // Counted burst on channel 1.
    wr(5'd18, 32'h0001_0001);
    wr(5'd19, 32'h0000_0303);
    prev = led_vec[1];
    wr(5'd0, 32'h2);
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      if (led_vec[1] && !prev) pulses++;
      prev = led_vec[1];
      cycle();
    end
    chk("burst_pulses", 32'(pulses), 32'd3);
    rd(5'd1, v); chk("burst_done", 32'(v[9]), 32'd1);
    wr(5'd1, 32'h200);
    rd(5'd1, v); chk("burst_done_w1c", 32'(v[9]), 32'd0);

    // Burst with count 0 completes one cycle after the restart write.
    wr(5'd0, 32'h6);
    wr(5'd20, 32'h0001_0001);
    wr(5'd21, 32'h0000_0003);
    rd(5'd1, v); chk("cnt0_done_early", 32'(v[10]), 32'd0);
    cycle();
    rd(5'd1, v); chk("cnt0_done", 32'(v[10]), 32'd1);
    run(6);

    // Disable mid-ON, then re-enable for a full on phase.
    wr(5'd0, 32'h1);
    cycle();
    wr(5'd0, 32'h0);
    chk("disable_low", 32'(led_vec[0]), 32'd0);
    run(3);
    wr(5'd0, 32'h1);
    pat[4] = led_vec[0];
    for (int k = 3; k >= 0; k--) begin cycle(); pat[k] = led_vec[0]; end
    chk("reenable_pattern", 32'(pat[4:0]), 32'(5'b11100));

    // Off time 0 gives steady high; prescale 0 behaves as 1.
    wr(5'd22, 32'h0000_0002);
    wr(5'd23, 32'd2);
    wr(5'd0, 32'h9);
    wr(5'd2, 32'd0);
    rd(5'd2, v); chk("prescale0_rb", v, 32'd0);
    run(20);

    // Prescale 4, all channels blinking with distinct times.
    wr(5'd2, 32'd4);
    for (int i = 0; i < 8; i++) begin
      wr(5'(16 + 2 * i), {16'(i + 1), 16'(i + 2)});
      wr(5'(17 + 2 * i), 32'd2);
    end
    wr(5'd0, 32'hFF);
    run(250);
    for (int a = 0; a < 32; a++) rd_model(5'(a));

    // Reset in mid-operation.
    reset = 1'b1; cycle(); reset = 1'b0;
    rd(5'd2, v); chk("midreset_prescale", v, 32'd100000);
    rd(5'd16, v); chk("midreset_time0", v, 32'd0);
    wr(5'd2, 32'd1);

    // Randomized traffic against the model.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 9))
        0, 1: wr(5'(16 + 2 * $urandom_range(0, 7)),
                 {16'($urandom_range(0, 4)), 16'($urandom_range(0, 4))});
        2, 3: wr(5'(17 + 2 * $urandom_range(0, 7)),
                 {16'd0, 8'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3))});
        4: wr(5'd0, $urandom);
        5: wr(5'd1, $urandom);
        6: wr(5'd2, 32'($urandom_range(0, 3)));
        7: wr(5'($urandom_range(3, 15)), $urandom);
        8: rd_model(5'($urandom_range(0, 31)));
        default: run($urandom_range(1, 25));
      endcase
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1; cycle(); reset = 1'b0;
        wr(5'd2, 32'($urandom_range(0, 3)));
      end
    end
    for (int a = 0; a < 32; a++) rd_model(5'(a));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
